dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use one clock `clk` and a synchronous, active-high reset `rst`; all state SHALL change only on posedge `clk`.
REQ-002 Port list (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `a_req` in 1: requester A (pipeline MEM stage) access request.
- `a_we` in 1: A write (1) / read (0).
- `a_addr` in 32: A byte address.
- `a_wdata` in 32: A write data.
- `a_gnt` out 1: A request accepted this cycle.
- `a_done` out 1: A access complete (1-cycle pulse).
- `a_rdata` out 32: A read data, valid with `a_done`.
- `a_err` out 1: A access rejected, valid with `a_done`.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_done`, `b_rdata`, `b_err`: the same for requester B (loader/debug port).
- `mem_addr` out 32: data memory Address.
- `mem_wdata` out 32: data memory WriteData.
- `mem_write` out 1: data memory MemWrite.
- `mem_read` out 1: data memory MemRead.
- `mem_rdata` in 32: data memory ReadData (combinational).
- `busy` out 1: access in flight.

Function
REQ-003 The FSM SHALL have two states: IDLE and SERVE.
REQ-004 Grants SHALL be issued only in IDLE, combinationally: `x_gnt`=1 for the winner when its `x_req`=1; the handshake completes on `x_req & x_gnt`.
REQ-005 On a handshake, the winner's `we`, `addr` and `wdata` SHALL be captured and the FSM SHALL go to SERVE.
REQ-006 SERVE SHALL last exactly one cycle, with no grants; the FSM SHALL then return to IDLE.
REQ-007 In SERVE, `mem_addr`/`mem_wdata` SHALL carry the captured values, and `mem_write`=we, `mem_read`=!we. Both strobes SHALL be 0 in IDLE; `mem_addr`/`mem_wdata` SHALL hold their last value.
REQ-008 At the end of SERVE, `x_done` SHALL be registered high for one cycle for the served requester. `x_rdata` SHALL be registered from `mem_rdata` on a read and be 0 on a write.
REQ-009 Latency: handshake edge E0 -> memory access in cycle E0+1 -> `done` in cycle E0+2. Peak throughput SHALL be one access per 2 cycles; a new grant MAY coincide with `done`.
REQ-010 Arbitration SHALL be round-robin. On simultaneous requests, the requester not served last SHALL win. A lone requester SHALL always win.
REQ-011 `x_rdata` SHALL hold its value until the next `done` for that requester.
REQ-012 `busy` SHALL be 1 exactly in SERVE.

Reset
REQ-013 Reset SHALL set: state IDLE; last-served = B, so A wins the first tie; all `gnt`/`done`/`err`/`mem_write`/`mem_read` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0.
REQ-014 `rst` asserted during SERVE: the write strobe of that cycle still reaches memory at that edge, but no `done` SHALL be issued and the FSM SHALL return to IDLE.

Configuration
REQ-015 Macro `DMEM_ARB_RANGE_CHECK_EN`:
- Defined: an access with `addr[1:0]`!=0 or `addr` > MEM_TOP_ADDR (40) SHALL assert no memory strobe in SERVE. It SHALL complete with `err`=1 and `rdata`=0.
- Undefined: `err` SHALL be tied 0 and all addresses SHALL pass through unchanged.

Structure
REQ-016 Package `dmem_arb_pkg` SHALL hold: state enum (IDLE, SERVE), port-ID constants (PORT_A, PORT_B), MEM_TOP_ADDR=40, data/address widths.
REQ-017 The 2-way round-robin winner logic SHALL live in sub-module `dmem_arb_rr_pick`.

Verification
REQ-018 After reset, A writes 0x0000_00AA at 8, then reads 8 -> `mem_write` 1 cycle with `mem_addr`=8; read `a_done` returns 0xAA two cycles after the grant.
REQ-019 `a_req` and `b_req` held high together from reset -> grants alternate A, B, A, B, one every 2 cycles.
REQ-020 Only B requests, 4 consecutive reads of 0, 4, 8, 12 -> all granted to B; `a_gnt` never 1.
REQ-021 `rst` pulsed in the SERVE cycle of an A read -> no `a_done`; `busy`=0 the next cycle; next tie goes to A.
REQ-022 With `DMEM_ARB_RANGE_CHECK_EN`, A reads addresses 6 and 44 -> both give `a_err`=1, `a_rdata`=0, `mem_read` never asserted. Without the macro, the same accesses give `a_err`=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature: define DMEM_ARB_RANGE_CHECK_EN to reject misaligned or
// out-of-range addresses instead of passing them to memory.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Highest legal word address when range checking is enabled
    localparam logic [ADDR_W-1:0] MEM_TOP_ADDR = ADDR_W'(40);

    // Requester identifiers
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Request payload captured at the handshake
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Word-aligned and not beyond the top of memory
    function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= MEM_TOP_ADDR);
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Two-way round-robin winner selection; purely combinational.
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic reqA,
    input  logic reqB,
    input  logic lastServed,
    output logic pickA_c,
    output logic pickB_c
);

    // A lone requester wins; on a tie the one not served last wins
    always_comb begin
        pickA_c = reqA & (~reqB | (lastServed == PORT_B));
        pickB_c = reqB & (~reqA | (lastServed == PORT_A));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory.
// Each access takes a one-cycle SERVE slot; done returns one cycle later.
// Optional feature: DMEM_ARB_RANGE_CHECK_EN (address range/alignment check).
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic              lastServed;
    logic              served;
    logic              capWe;
    logic              capOk;

    logic              pickA_c;
    logic              pickB_c;
    logic              hsA_c;
    logic              hsB_c;
    mem_req_t          win_c;
    logic              winOk_c;
    logic [DATA_W-1:0] doneRdata_c;
    logic              doneErr_c;

    dmem_arb_rr_pick u_pick (
        .reqA       (a_req),
        .reqB       (b_req),
        .lastServed (lastServed),
        .pickA_c    (pickA_c),
        .pickB_c    (pickB_c)
    );

    // Next state and grants; grants only in IDLE and never while in reset
    always_comb begin
        stateNext = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        hsA_c     = 1'b0;
        hsB_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    a_gnt = pickA_c;
                    b_gnt = pickB_c;
                end
                hsA_c = a_req & a_gnt;
                hsB_c = b_req & b_gnt;
                if (hsA_c || hsB_c) begin
                    stateNext = SERVE;
                end
            end
            SERVE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Winner payload and its address check
    always_comb begin
        win_c = '0;
        if (hsB_c) begin
            win_c.we    = b_we;
            win_c.addr  = b_addr;
            win_c.wdata = b_wdata;
        end else begin
            win_c.we    = a_we;
            win_c.addr  = a_addr;
            win_c.wdata = a_wdata;
        end
`ifdef DMEM_ARB_RANGE_CHECK_EN
        winOk_c = addrInRange(win_c.addr);
`else
        winOk_c = 1'b1;
`endif
    end

    // Completion data: writes and rejected accesses return zero
    always_comb begin
        doneRdata_c = '0;
        doneErr_c   = ~capOk;
        if (!capWe && capOk) begin
            doneRdata_c = mem_rdata;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Capture at handshake, drive memory in SERVE, report completion after
    always_ff @(posedge clk) begin
        if (rst) begin
            lastServed <= PORT_B;
            served     <= PORT_A;
            capWe      <= 1'b0;
            capOk      <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            busy       <= 1'b0;
            a_done     <= 1'b0;
            a_rdata    <= '0;
            a_err      <= 1'b0;
            b_done     <= 1'b0;
            b_rdata    <= '0;
            b_err      <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            busy      <= (stateNext == SERVE);

            if (hsA_c || hsB_c) begin
                served     <= hsB_c ? PORT_B : PORT_A;
                lastServed <= hsB_c ? PORT_B : PORT_A;
                capWe      <= win_c.we;
                capOk      <= winOk_c;
                mem_addr   <= win_c.addr;
                mem_wdata  <= win_c.wdata;
                mem_write  <= win_c.we & winOk_c;
                mem_read   <= ~win_c.we & winOk_c;
            end

            if (state == SERVE) begin
                if (served == PORT_A) begin
                    a_done  <= 1'b1;
                    a_rdata <= doneRdata_c;
                    a_err   <= doneErr_c;
                end else begin
                    b_done  <= 1'b1;
                    b_rdata <= doneRdata_c;
                    b_err   <= doneErr_c;
                end
            end
        end
    end

endmodule
